// File: rtl/mkey_pkg.sv
// ============================================================================
// Module      : mkey_pkg
// Description : Shared types and constants for the magkey latch controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mkey_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    HOLD = 2'd2
  } mkey_state_t;

  localparam int STROBE_BIT = 7;
  localparam int CODE_W     = 7;

endpackage

`default_nettype wire

// File: rtl/mkey_repeat_timer.sv
// ============================================================================
// Module      : mkey_repeat_timer
// Description : Loadable saturating down-counter that paces key auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mkey_repeat_timer #(
  parameter int               CNT_W        = 24,
  parameter logic [CNT_W-1:0] REPEAT_DELAY = 24'd500000,
  parameter logic [CNT_W-1:0] REPEAT_RATE  = 24'd66000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_delay,
  input  logic load_rate,
  input  logic en,
  output logic zero
);

  // The counter holds the remaining cycles minus one, so zero is reached
  // exactly one period after the load and the repeat lands on that period.
  localparam logic [CNT_W-1:0] c_delay_m1 = REPEAT_DELAY - CNT_W'(1);
  localparam logic [CNT_W-1:0] c_rate_m1  = REPEAT_RATE  - CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load_delay) begin
      r_cnt <= c_delay_m1;
    end else if (load_rate) begin
      r_cnt <= c_rate_m1;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mkey_latch_ctrl.sv
// ============================================================================
// Module      : mkey_latch_ctrl
// Description : Pops key codes from the keyboard FIFO, holds them behind a
//               software-cleared strobe and generates auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mkey_latch_ctrl
  import mkey_pkg::*;
#(
  parameter int               CNT_W        = 24,
  parameter logic [CNT_W-1:0] REPEAT_DELAY = 24'd500000,
  parameter logic [CNT_W-1:0] REPEAT_RATE  = 24'd66000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_kcode,
  output logic       fifo_rdreq,
  input  logic       key_held,
  input  logic       kbd_rd,
  input  logic       kbd_clr,
  output logic [7:0] key_data,
  output logic       strobe
);

  mkey_state_t       r_state, w_state_nxt;
  logic [CODE_W-1:0] r_code, w_code_nxt;
  logic              r_strobe, w_strobe_nxt;
  logic              r_rdreq, w_rdreq_nxt;
  logic              w_load_delay, w_load_rate;
  logic              w_zero, w_armed;
  logic              w_unused;

  // kbd_rd is informational and the FIFO code MSB carries nothing we use.
  assign w_unused = &{1'b0, kbd_rd, fifo_kcode[7]};

  mkey_repeat_timer #(
    .CNT_W        (CNT_W),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_delay (w_load_delay),
    .load_rate  (w_load_rate),
    .en         (key_held),
    .zero       (w_zero)
  );

  assign w_armed = w_zero & key_held;

  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_strobe_nxt = r_strobe;
    w_rdreq_nxt  = r_rdreq;
    w_load_delay = 1'b0;
    w_load_rate  = 1'b0;
    case (r_state)
      IDLE: begin
        // A fresh FIFO key always wins over a pending repeat.
        if (!fifo_empty) begin
          w_code_nxt   = fifo_kcode[CODE_W-1:0];
          w_strobe_nxt = 1'b1;
          w_rdreq_nxt  = 1'b1;
          w_load_delay = 1'b1;
          w_state_nxt  = POP;
        end else if (w_armed) begin
          w_strobe_nxt = 1'b1;
          w_load_rate  = 1'b1;
          w_state_nxt  = HOLD;
        end
      end
      POP: begin
        w_rdreq_nxt = 1'b0;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (kbd_clr) begin
          w_strobe_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end
      end
      default: begin
        w_strobe_nxt = 1'b0;
        w_rdreq_nxt  = 1'b0;
        w_state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_code   <= '0;
      r_strobe <= 1'b0;
      r_rdreq  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_strobe <= w_strobe_nxt;
      r_rdreq  <= w_rdreq_nxt;
    end
  end

  assign key_data[STROBE_BIT]   = r_strobe;
  assign key_data[CODE_W-1:0]   = r_code;
  assign strobe                 = r_strobe;
  assign fifo_rdreq             = r_rdreq;

endmodule

`default_nettype wire

// File: tb/tb_mkey_latch_ctrl.sv
// ============================================================================
// Module      : tb_mkey_latch_ctrl
// Description : Directed scoreboard bench for mkey_latch_ctrl with a FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mkey_latch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_empty;
  logic [7:0] fifo_kcode;
  logic       fifo_rdreq;
  logic       key_held;
  logic       kbd_rd;
  logic       kbd_clr;
  logic [7:0] key_data;
  logic       strobe;

  always #5 clk = ~clk;

  mkey_latch_ctrl #(
    .CNT_W        (24),
    .REPEAT_DELAY (24'd10),
    .REPEAT_RATE  (24'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_kcode (fifo_kcode),
    .fifo_rdreq (fifo_rdreq),
    .key_held   (key_held),
    .kbd_rd     (kbd_rd),
    .kbd_clr    (kbd_clr),
    .key_data   (key_data),
    .strobe     (strobe)
  );

  // 8-entry FIFO model that advances on the rising edge of its read request.
  logic [7:0]  fmem [0:7];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int          edges  = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_kcode = fmem[rd_ptr[2:0]];

  always @(posedge fifo_rdreq) begin
    edges <= edges + 1;
    if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
  end

  task automatic fifo_push(input logic [7:0] code);
    fmem[wr_ptr[2:0]] = code;
    wr_ptr = wr_ptr + 1;
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] kd;
    logic       rq;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   compared   = 0;
  int   mismatched = 0;

  task automatic expect_at(input int d, input logic [7:0] kd, input logic rq, input string tag);
    exp_t e;
    e.cyc = cyc + d;
    e.kd  = kd;
    e.rq  = rq;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_due();
    int i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        exp_t e = sb[i];
        sb.delete(i);
        compared++;
        assert ({strobe, key_data, fifo_rdreq} === {e.kd[7], e.kd, e.rq}) else begin
          mismatched++;
          $error("FAIL %s @cyc %0d: observed strobe=%b key_data=%h rdreq=%b, expected strobe=%b key_data=%h rdreq=%b",
                 e.tag, cyc, strobe, key_data, fifo_rdreq, e.kd[7], e.kd, e.rq);
        end
      end else begin
        i++;
      end
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_due();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0;
    for (int k = 0; k < 8; k++) fmem[k] = 8'h00;
    rst_n    = 1'b0;
    key_held = 1'b0;
    kbd_rd   = 1'b0;
    kbd_clr  = 1'b0;

    // Reset state
    expect_at(1, 8'h00, 1'b0, "reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset during POP discards the popped code
    fifo_push(8'h33);
    expect_at(1, 8'hB3, 1'b1, "t1_load");
    tick();
    rst_n = 1'b0;
    expect_at(1, 8'h00, 1'b0, "t1_rst_pop");
    tick();
    rst_n = 1'b1;
    expect_at(1, 8'h00, 1'b0, "t1_after");
    tick();

    // Single key with FIFO MSB set
    fifo_push(8'hC1);
    expect_at(1, 8'hC1, 1'b1, "t2_load");
    expect_at(2, 8'hC1, 1'b0, "t2_pop");
    tick();
    tick();
    tick();
    tick();
    kbd_clr = 1'b1;
    kbd_rd  = 1'b1;
    expect_at(1, 8'h41, 1'b0, "t2_clr");
    tick();
    kbd_clr = 1'b0;
    kbd_rd  = 1'b0;

    // Back-to-back keys
    e0 = edges;
    fifo_push(8'h41);
    fifo_push(8'h42);
    expect_at(1, 8'hC1, 1'b1, "t3_load1");
    expect_at(2, 8'hC1, 1'b0, "t3_pop1");
    tick();
    tick();
    kbd_clr = 1'b1;
    expect_at(1, 8'h41, 1'b0, "t3_clr1");
    expect_at(2, 8'hC2, 1'b1, "t3_load2");
    expect_at(3, 8'hC2, 1'b0, "t3_pop2");
    tick();
    kbd_clr = 1'b0;
    tick();
    tick();
    kbd_clr = 1'b1;
    expect_at(1, 8'h42, 1'b0, "t3_clr2");
    tick();
    kbd_clr = 1'b0;
    tick();
    cmp_int("t3_rdreq_edges", edges - e0, 2);

    // Clear and non-empty FIFO in the same cycle
    fifo_push(8'h10);
    expect_at(1, 8'h90, 1'b1, "t4_pre_load");
    tick();
    tick();
    kbd_clr = 1'b1;
    fifo_push(8'h5A);
    expect_at(1, 8'h10, 1'b0, "t4_clr_first");
    expect_at(2, 8'hDA, 1'b1, "t4_load");
    tick();
    kbd_clr = 1'b0;
    tick();
    tick();
    kbd_clr = 1'b1;
    expect_at(1, 8'h5A, 1'b0, "t4_clr");
    tick();
    kbd_clr = 1'b0;

    // Auto-repeat: first after the delay, then at the rate, stops on release
    key_held = 1'b1;
    fifo_push(8'h41);
    expect_at(1, 8'hC1, 1'b1, "t5_latch");
    tick();
    tick();
    kbd_clr = 1'b1;
    expect_at(1, 8'h41, 1'b0, "t5_clr0");
    tick();
    kbd_clr = 1'b0;
    for (int k = 1; k <= 7; k++) expect_at(k, 8'h41, 1'b0, "t5_wait_delay");
    expect_at(8, 8'hC1, 1'b0, "t5_rep1");
    for (int k = 0; k < 8; k++) tick();
    kbd_clr = 1'b1;
    for (int k = 1; k <= 3; k++) expect_at(k, 8'h41, 1'b0, "t5_wait_rate");
    expect_at(4, 8'hC1, 1'b0, "t5_rep2");
    tick();
    kbd_clr = 1'b0;
    tick();
    tick();
    tick();
    kbd_clr  = 1'b1;
    key_held = 1'b0;
    for (int k = 1; k <= 9; k++) expect_at(k, 8'h41, 1'b0, "t5_norep");
    tick();
    kbd_clr = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    // Clear pulses in IDLE do nothing
    e0 = edges;
    for (int k = 0; k < 4; k++) begin
      kbd_clr = (k % 2 == 0);
      expect_at(1, 8'h41, 1'b0, "t6_idle_clr");
      tick();
    end
    kbd_clr = 1'b0;
    tick();
    cmp_int("t6_rdreq_edges", edges - e0, 0);

    cmp_int("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mkey_latch_ctrl.md
# mkey_latch_ctrl

Keyboard latch controller between the keyboard ring FIFO (8-entry, advanced on the rising edge of its read request) and the CPU keyboard registers. Pops one key code at a time, holds it with a strobe bit until software clears it, and generates auto-repeat of the held key. Sits in the magkey subsystem, clocked by the system clock.

## Interface

Parameters:
- `REPEAT_DELAY`, default 24'd500000: cycles from a key latch to the first auto-repeat.
- `REPEAT_RATE`, default 24'd66000: cycles between subsequent auto-repeats.
- `CNT_W`, default 24: repeat counter width. `REPEAT_DELAY` and `REPEAT_RATE` must both be ≥2 and fit in `CNT_W`.

Ports:
- `clk`, in, 1: system clock. The block has only this clock.
- `rst_n`, in, 1: reset. Synchronous and active-low.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_kcode`, in, 8: FIFO head code, combinational from the FIFO.
- `fifo_rdreq`, out, 1: FIFO pop request; the FIFO pops on its rising edge.
- `key_held`, in, 1: a key is physically down, already synchronised.
- `kbd_rd`, in, 1: one-cycle pulse on a CPU read of the data register. Informational; it has no state effect.
- `kbd_clr`, in, 1: one-cycle pulse on a CPU strobe-clear access.
- `key_data`, out, 8: `{strobe, code[6:0]}`.
- `strobe`, out, 1: key-available flag.

## Operation

States: `IDLE`, `POP`, `HOLD`.

- **IDLE**: strobe is clear.
  - If `!fifo_empty`: latch `fifo_kcode[6:0]`, set strobe, raise `fifo_rdreq`, load the repeat counter with `REPEAT_DELAY`, go to `POP`.
  - Otherwise, if the repeat is armed (see below), re-set strobe with the same code, load `REPEAT_RATE`, go to `HOLD`.
- **POP**: drop `fifo_rdreq`, go to `HOLD`. This guarantees exactly one rising edge per pop and at least one low cycle between pops.
- **HOLD**: strobe is set.
  - `kbd_clr` clears strobe and moves to `IDLE`.
  - The repeat counter keeps counting in `HOLD` and `IDLE`.

Repeat counter:
- Decrements each cycle while `key_held=1`.
- Saturates at 0.
- "Armed" means the counter is 0 and `key_held=1`.
- `key_held=0` disarms the repeat and freezes the counter at 0 with no repeat.
- A newly popped FIFO key always takes priority over a repeat.

Other rules:
- The code register keeps its last value after a clear. Bit 7 of `key_data` always equals `strobe`.
- `kbd_clr` in `IDLE` or `POP` has no effect. In `POP`, the clear is lost: strobe remains set.
- `fifo_kcode[7]` is ignored.

## Timing

- **Reset** (`rst_n=0` at a rising `clk`): state `IDLE`, `fifo_rdreq=0`, `strobe=0`, `key_data=8'h00`, counter 0. Applies mid-`POP` as well: `rdreq` drops, and the popped code is discarded.
- **Load latency**: `fifo_empty` low in cycle N with the block in `IDLE` gives `strobe`, `key_data` and `fifo_rdreq` high in cycle N+1, and `fifo_rdreq` low in cycle N+2.
- **Clear latency**: `kbd_clr` in cycle N (in `HOLD`) gives `strobe=0` in cycle N+1.
  - The earliest next load is set in cycle N+2, because `IDLE` must be occupied for one cycle.
- **Simultaneous `kbd_clr` and non-empty FIFO**: the clear is taken first; the next key loads one cycle later.
- **Back-to-back keys**: the minimum spacing is 3 cycles per key (load, pop-release, clear).
- **First repeat**: occurs `REPEAT_DELAY` cycles after a latch, provided strobe has been cleared.
  - If strobe is still set when the counter reaches 0, the repeat fires in the first `IDLE` cycle after the clear.
- **Full FIFO**: no special handling. The controller drains at CPU pace.

## Structure

- Package `mkey_pkg`:
  - state enum `mkey_state_t`: `IDLE`, `POP`, `HOLD`.
  - `STROBE_BIT = 7`.
  - `CODE_W = 7`.
- Sub-module `mkey_repeat_timer`:
  - Loadable down-counter (`CNT_W`).
  - Inputs: `load_delay`, `load_rate`, `en`.
  - Output: `zero`.
- The remaining FSM, code register and strobe logic live in `mkey_latch_ctrl`.

## Test plan

Use `REPEAT_DELAY=10` and `REPEAT_RATE=4` unless noted.

1. **Reset mid-POP**: assert `rst_n=0` in the `POP` cycle → the next cycle shows `fifo_rdreq=0`, `strobe=0`, `key_data=8'h00`.
2. **Single key**: FIFO holds `8'hC1`, `fifo_empty` falls in cycle 5 → cycle 6: `key_data=8'hC1`, `fifo_rdreq=1`; cycle 7: `fifo_rdreq=0`; `kbd_clr` in cycle 9 → cycle 10: `key_data=8'h41`.
3. **Back-to-back**: FIFO holds `8'h41`,`8'h42`, with `kbd_clr` the cycle after each strobe → exactly 2 `fifo_rdreq` rising edges, each followed by a low cycle; codes appear in order; strobe re-sets 2 cycles after the first clear.
4. **Simultaneous**: `kbd_clr` in the same cycle the FIFO goes non-empty with `8'h5A` → strobe=0 for one cycle, then `key_data=8'hDA`.
5. **Auto-repeat**: latch `8'h41`, clear at once, hold `key_held=1`, FIFO empty → strobe re-sets with `8'hC1` 10 cycles after the latch, then every 4 cycles with prompt clears; `key_held=0` → no further strobes.
6. **Clear ignored in IDLE**: `kbd_clr` pulses while the block is in `IDLE` → no state change, and no `fifo_rdreq` activity.
